// File: rtl/ahb_apb_bridge.sv
// AHB slave to APB3 bridge: one APB transfer per selected AHB transfer, wait states
// while the APB side runs, and a two-cycle AHB ERROR on PSLVERR or PREADY timeout.
//
// state  | meaning
// IDLE   | ready, waiting for an accepted AHB address phase
// LATCH  | AHB data phase: capture HWDATA for writes
// SETUP  | APB setup phase (PSEL=1, PENABLE=0)
// ACCESS | APB access phase, waiting for PREADY or timeout
// ERR1   | first ERROR cycle, HREADY low, APB released
// ERR2   | second ERROR cycle, HREADY high, may accept next transfer
module ahb_apb_bridge #(
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int AHB_DATA_WIDTH = 32,
   parameter int APB_ADDR_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      HSEL,
   input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]                HTRANS,
   input  logic                      HWRITE,
   input  logic [AHB_DATA_WIDTH-1:0] HWDATA,
   output logic [AHB_DATA_WIDTH-1:0] HRDATA,
   output logic [1:0]                HRESP,
   output logic                      HREADY,
   output logic                      PSEL,
   output logic                      PENABLE,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic                      PWRITE,
   output logic [AHB_DATA_WIDTH-1:0] PWDATA,
   input  logic [AHB_DATA_WIDTH-1:0] PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LATCH, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             psel_d, penable_d, hready_d, herr_d;

   // Upper address bits and the SEQ/NONSEQ distinction are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{HADDR[AHB_ADDR_WIDTH-1:APB_ADDR_WIDTH], HTRANS[0]};

   assign accept = ((state == ST_IDLE) || (state == ST_ERR2)) && HSEL && HTRANS[1];

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept) state_nxt = ST_LATCH;
         ST_LATCH:  state_nxt = ST_SETUP;
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (PREADY)               state_nxt = PSLVERR ? ST_ERR1 : ST_IDLE;
            else if (cnt == CNT_LAST) state_nxt = ST_ERR1;
         end
         ST_ERR1:   state_nxt = ST_ERR2;
         ST_ERR2:   state_nxt = accept ? ST_LATCH : ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      psel_d    = (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
      penable_d = (state_nxt == ST_ACCESS);
      hready_d  = (state_nxt == ST_IDLE) || (state_nxt == ST_ERR2);
      herr_d    = (state_nxt == ST_ERR1) || (state_nxt == ST_ERR2);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         PSEL    <= 1'b0;
         PENABLE <= 1'b0;
         HREADY  <= 1'b1;
         HRESP   <= 2'b00;
      end else begin
         PSEL    <= psel_d;
         PENABLE <= penable_d;
         HREADY  <= hready_d;
         HRESP   <= {1'b0, herr_d};
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         PADDR  <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
         HRDATA <= '0;
         cnt    <= '0;
      end else begin
         if (accept) begin
            PADDR  <= HADDR[APB_ADDR_WIDTH-1:0];
            PWRITE <= HWRITE;
         end
         if ((state == ST_LATCH) && PWRITE) PWDATA <= HWDATA;
         if ((state == ST_ACCESS) && PREADY && !PSLVERR && !PWRITE) HRDATA <= PRDATA;
         if (state_nxt == ST_SETUP)                cnt <= '0;
         else if ((state == ST_ACCESS) && !PREADY) cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Scoreboard bench for ahb_apb_bridge: AHB expectations and APB phase expectations
// are queued when a transfer is issued and checked as the bridge produces them.
module tb_ahb_apb_bridge;

   localparam int TO = 4;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = 2'b00;
   logic        HWRITE = 1'b0;
   logic [31:0] HWDATA = '0;
   logic [31:0] HRDATA;
   logic [1:0]  HRESP;
   logic        HREADY;
   logic        PSEL, PENABLE, PWRITE;
   logic [15:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA = '0;
   logic        PREADY = 1'b0;
   logic        PSLVERR = 1'b0;

   ahb_apb_bridge #(
      .AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .APB_ADDR_WIDTH(16), .TIMEOUT_CYCLES(TO)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY),
      .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [15:0] paddr;
      logic        pwrite;
      logic [31:0] pwdata;
      int          wait_n;
      logic        err;
      logic [31:0] prd;
   } apb_exp_t;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] rdata;
      int          low;
   } ahb_exp_t;

   apb_exp_t    apb_q[$];
   ahb_exp_t    ahb_q[$];
   apb_exp_t    cur;
   int          checks = 0;
   int          errors = 0;
   int          acc = 0;
   int          setups = 0;
   int          n_xfers = 0;
   logic [31:0] rd_model = '0;
   logic [31:0] wd_next = '0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   // APB slave model: checks each SETUP against the queue, then answers after wait_n cycles.
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         PREADY  = 1'b0;
         PSLVERR = 1'b0;
         acc     = 0;
      end else if (PSEL && !PENABLE) begin
         if (apb_q.size() == 0) begin
            chk("apb_unexpected_setup", 32'(PSEL), 32'd0);
         end else begin
            cur = apb_q.pop_front();
            setups++;
            chk("paddr", 32'(PADDR), 32'(cur.paddr));
            chk("pwrite", 32'(PWRITE), 32'(cur.pwrite));
            if (cur.pwrite) chk("pwdata", PWDATA, cur.pwdata);
         end
         acc     = 0;
         PREADY  = 1'b0;
         PSLVERR = 1'b0;
      end else if (PSEL && PENABLE) begin
         chk("paddr_stable", 32'(PADDR), 32'(cur.paddr));
         if (cur.pwrite) chk("pwdata_stable", PWDATA, cur.pwdata);
         if (acc == cur.wait_n) begin
            PREADY  = 1'b1;
            PSLVERR = cur.err;
            PRDATA  = cur.prd;
         end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
         end
         acc++;
      end else begin
         PREADY  = 1'b0;
         PSLVERR = 1'b0;
      end
   end

   // Drive an address phase at the current negedge and queue what it should produce.
   task automatic start(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input int wn, input logic er, input logic [31:0] pd);
      apb_exp_t ae;
      ahb_exp_t he;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; wd_next = wd;
      ae.paddr = a[15:0]; ae.pwrite = wr; ae.pwdata = wd;
      ae.wait_n = wn; ae.err = er; ae.prd = pd;
      apb_q.push_back(ae);
      if (wn >= TO) begin
         he.resp = 2'b01; he.low = 3 + TO;
      end else if (er) begin
         he.resp = 2'b01; he.low = wn + 4;
      end else begin
         he.resp = 2'b00; he.low = wn + 3;
         if (!wr) rd_model = pd;
      end
      he.rdata = rd_model;
      ahb_q.push_back(he);
      n_xfers++;
   endtask

   // Run the data phase until HREADY returns; leaves the caller in the completion cycle.
   task automatic finish_xfer();
      ahb_exp_t he;
      int n = 0, psel_at = 0, pen_at = 0;
      bit seen_err1 = 0;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd_next;
      while (!HREADY && n < 40) begin
         n++;
         if (PSEL && psel_at == 0) psel_at = n;
         if (PENABLE && pen_at == 0) pen_at = n;
         if (HRESP == 2'b01) begin
            chk("err1_apb_released", {30'd0, PSEL, PENABLE}, 32'd0);
            seen_err1 = 1;
         end
         @(negedge HCLK);
      end
      if (ahb_q.size() == 0) begin
         chk("ahb_unexpected_completion", 32'(HREADY), 32'd0);
      end else begin
         he = ahb_q.pop_front();
         chk("hready_low_cycles", 32'(n), 32'(he.low));
         chk("hresp", 32'(HRESP), 32'(he.resp));
         chk("hrdata", HRDATA, he.rdata);
         chk("psel_cycle", 32'(psel_at), 32'd2);
         chk("penable_cycle", 32'(pen_at), 32'd3);
         if (he.resp == 2'b01) chk("err1_seen", 32'(seen_err1), 32'd1);
      end
   endtask

   task automatic check_idle();
      @(negedge HCLK);
      chk("idle_hready", 32'(HREADY), 32'd1);
      chk("idle_hresp", 32'(HRESP), 32'd0);
      chk("idle_psel", 32'(PSEL), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge HCLK);
      chk("rst_hready", 32'(HREADY), 32'd1);
      chk("rst_hresp", 32'(HRESP), 32'd0);
      chk("rst_hrdata", HRDATA, 32'd0);
      chk("rst_psel_penable", {30'd0, PSEL, PENABLE}, 32'd0);
      chk("rst_paddr", 32'(PADDR), 32'd0);
      chk("rst_pwrite_pwdata", {PWDATA[30:0], PWRITE}, 32'd0);
      HRESETn = 1'b1;
      @(negedge HCLK);

      start(32'h4000_0010, 1'b1, 32'h0000_1234, 0, 1'b0, 32'h0);
      finish_xfer();
      check_idle();

      start(32'h4000_0020, 1'b0, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);
      finish_xfer();
      check_idle();

      start(32'h4000_0030, 1'b1, 32'h5555_AAAA, 0, 1'b1, 32'h0);
      finish_xfer();
      check_idle();

      start(32'h4000_0034, 1'b0, 32'h0, 99, 1'b0, 32'h1111_2222);
      finish_xfer();
      check_idle();

      start(32'h4000_0040, 1'b1, 32'hA5A5_0001, 0, 1'b0, 32'h0);
      finish_xfer();
      start(32'h4000_0044, 1'b0, 32'h0, 1, 1'b0, 32'hCAFE_F00D);
      finish_xfer();
      start(32'h4000_0048, 1'b0, 32'h0, 0, 1'b1, 32'h0BAD_0BAD);
      finish_xfer();
      start(32'h4000_004C, 1'b0, 32'h0, 0, 1'b0, 32'h1357_9BDF);
      finish_xfer();
      check_idle();

      HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h4000_0050;
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         chk("busy_no_psel", {30'd0, PSEL, HREADY}, 32'd1);
      end
      HSEL = 1'b0; HTRANS = 2'b00;

      for (int i = 0; i < 4; i++) begin
         start({16'h4000, 16'($urandom_range(0, 65535))}, 1'(i % 2), $urandom,
               int'($urandom_range(0, 2)), 1'b0, $urandom);
         finish_xfer();
      end
      check_idle();

      start(32'h4000_0060, 1'b0, 32'h0, 99, 1'b0, 32'h0);
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00;
      repeat (2) @(negedge HCLK);
      chk("pre_reset_penable", 32'(PENABLE), 32'd1);
      #2 HRESETn = 1'b0;
      #1;
      chk("async_rst_psel_penable", {30'd0, PSEL, PENABLE}, 32'd0);
      chk("async_rst_hready", 32'(HREADY), 32'd1);
      void'(ahb_q.pop_back());
      apb_q.delete();
      rd_model = '0;
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      start(32'h4000_0070, 1'b0, 32'h0, 1, 1'b0, 32'h7654_3210);
      finish_xfer();
      check_idle();

      chk("apb_setup_count", 32'(setups), 32'(n_xfers));
      chk("ahb_queue_drained", 32'(ahb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
